// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared types and sizes for the register-file write scheduler.
//   state_e      scheduler FSM states (ST_CLEAR, ST_RUN)
//   aux_entry_t  one aux queue slot: valid, destination register, data
//   NREG/REG_AW/XLEN  register count, register address width, data width
package rf_sched_pkg;

  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } aux_entry_t;

endpackage

// File: rtl/rf_aux_fifo.sv
// rf_aux_fifo: ordered queue of auxiliary register writes.
//   Circular storage with a per-entry valid bit, so that a writeback to the
//   same register can invalidate (squash) a queued write in place without
//   disturbing the order of the remaining entries.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              drop every entry (takes priority over all else)
//   push, push_rd/data enqueue one entry (caller guarantees room)
//   pop                retire the head entry (caller guarantees non-empty)
//   squash_en/rd       invalidate every stored entry targeting squash_rd
//   head               current head slot (valid may be 0 if squashed)
//   empty, full        occupancy flags (squashed slots still occupy space)
//   pend_mask          bit r set while a valid entry targets xr; bit 0 is 0
module rf_aux_fifo
  import rf_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [XLEN-1:0]   push_data,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [REG_AW-1:0] squash_rd,
  output aux_entry_t        head,
  output logic              empty,
  output logic              full,
  output logic [NREG-1:0]   pend_mask
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];

  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Squash only looks at already-stored entries; a same-cycle push to
      // the same register is newer than the writeback and must survive.
      if (squash_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (vld_q[i] && (rd_q[i] == squash_rd)) vld_d[i] = 1'b0;
        end
      end
      if (pop) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      // Applied after pop so a full-queue pop+push into the same slot
      // leaves the new entry valid.
      if (push) begin
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      rd_q[wr_ptr_q]   <= push_rd;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    head.valid = vld_q[rd_ptr_q];
    head.rd    = rd_q[rd_ptr_q];
    head.data  = data_q[rd_ptr_q];
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask[rd_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: rtl/rf_write_sched.sv
// rf_write_sched: owner of the register file's single write port.
//   Writeback has fixed priority and passes straight through; auxiliary
//   writes wait in rf_aux_fifo and use the port in writeback-idle cycles.
//   After reset (or clear_req) every register x1..x31 is written with 0.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   clear_req                   start a clear sequence (ignored while clearing)
//   wb_we, wb_rd, wb_data       writeback write
//   aux_valid/ready/rd/data     aux request handshake
//   rf_we, rf_ad, rf_wd         register file we3/ad3/wd3
//   stall_o                     high for every cycle of a clear sequence
//   starve_o                    ask the pipeline for a writeback bubble
//   aux_pend_mask               registers with a valid queued write
// Build option: define RF_SCHED_STARVE_EN to build the head age counter and
//   drive starve_o; without it starve_o is tied low.
module rf_write_sched
  import rf_sched_pkg::*;
#(
  parameter int AUX_DEPTH  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [REG_AW-1:0] aux_rd,
  input  logic [XLEN-1:0]   aux_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_ad,
  output logic [XLEN-1:0]   rf_wd,
  output logic              stall_o,
  output logic              starve_o,
  output logic [NREG-1:0]   aux_pend_mask
);

  localparam logic [REG_AW-1:0] IDX_FIRST = REG_AW'(1);
  localparam logic [REG_AW-1:0] IDX_LAST  = REG_AW'(NREG - 1);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] idx_q, idx_d;

  logic              run;
  logic              wb_hit;
  logic              head_wr;
  logic              fifo_pop;
  logic              fifo_push;
  logic              fifo_flush;
  logic              fifo_empty;
  logic              fifo_full;
  logic              aux_rdy;
  logic              starve_int;
  aux_entry_t        head;
  logic [NREG-1:0]   pend_mask;
  logic              port_we;
  logic [REG_AW-1:0] port_ad;
  logic [XLEN-1:0]   port_wd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= IDX_FIRST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_RUN;
          idx_d   = IDX_FIRST;
        end else begin
          idx_d = idx_q + REG_AW'(1);
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = IDX_FIRST;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = IDX_FIRST;
      end
    endcase
  end

  // Output logic: port mux and queue control
  always_comb begin
    run     = (state_q == ST_RUN);
    // A writeback to x0 is not a write and leaves the port to the queue.
    wb_hit  = wb_we && (wb_rd != '0);
    head_wr = run && !fifo_empty && head.valid && !wb_hit;
    // A squashed head is retired without a write even while writeback
    // holds the port.
    fifo_pop   = run && !fifo_empty && (!head.valid || !wb_hit);
    aux_rdy    = run && (!fifo_full || fifo_pop);
    fifo_push  = aux_valid && aux_rdy && (aux_rd != '0);
    fifo_flush = run && clear_req;

    port_we = 1'b0;
    port_ad = '0;
    port_wd = '0;
    if (!run) begin
      port_we = 1'b1;
      port_ad = idx_q;
    end else if (wb_hit) begin
      port_we = 1'b1;
      port_ad = wb_rd;
      port_wd = wb_data;
    end else if (head_wr) begin
      port_we = 1'b1;
      port_ad = head.rd;
      port_wd = head.data;
    end
  end

  rf_aux_fifo #(
    .DEPTH(AUX_DEPTH)
  ) u_aux_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_rd   (aux_rd),
    .push_data (aux_data),
    .pop       (fifo_pop),
    .squash_en (run && wb_hit),
    .squash_rd (wb_rd),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .pend_mask (pend_mask)
  );

`ifdef RF_SCHED_STARVE_EN
  localparam int              AGE_W   = $clog2(STARVE_LIM + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIM);

  logic [AGE_W-1:0] age_q, age_d;
  logic             head_wait;

  // Age of the head entry: cycles it was valid but lost the port.
  always_comb begin
    head_wait = run && !fifo_empty && head.valid && !head_wr;
    age_d     = age_q;
    if (!run || fifo_flush || fifo_pop) begin
      age_d = '0;
    end else if (head_wait && (age_q != AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end

  assign starve_int = (age_q >= AGE_MAX);
`else
  // No age counter: starve never asserts. The compare is constant false and
  // only keeps STARVE_LIM referenced in this build.
  assign starve_int = (STARVE_LIM < 0);
`endif

  // Every output is held low while reset is asserted.
  assign rf_we         = rst_n && port_we;
  assign rf_ad         = rst_n ? port_ad : '0;
  assign rf_wd         = rst_n ? port_wd : '0;
  assign stall_o       = rst_n && !run;
  assign aux_ready     = rst_n && aux_rdy;
  assign starve_o      = rst_n && starve_int;
  assign aux_pend_mask = rst_n ? pend_mask : '0;

endmodule

// File: tb/tb_rf_write_sched.sv
module tb_rf_write_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_ad;
  logic [31:0] rf_wd;
  logic        stall_o;
  logic        starve_o;
  logic [31:0] aux_pend_mask;

  int checks = 0;
  int errors = 0;

`ifdef RF_SCHED_STARVE_EN
  localparam logic STARVE_EN = 1'b1;
`else
  localparam logic STARVE_EN = 1'b0;
`endif

  rf_write_sched #(
    .AUX_DEPTH (4),
    .STARVE_LIM(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_req    (clear_req),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .aux_valid    (aux_valid),
    .aux_ready    (aux_ready),
    .aux_rd       (aux_rd),
    .aux_data     (aux_data),
    .rf_we        (rf_we),
    .rf_ad        (rf_ad),
    .rf_wd        (rf_wd),
    .stall_o      (stall_o),
    .starve_o     (starve_o),
    .aux_pend_mask(aux_pend_mask)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2
  // units later, well clear of either edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = d;
  endtask

  task automatic drive_aux(input logic v, input logic [4:0] rd, input logic [31:0] d);
    aux_valid = v;
    aux_rd    = rd;
    aux_data  = d;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    clear_req = 1'b0;
    drive_aux(1'b0, 5'd0, 32'h0);
    drive_wb(1'b1, 5'd9, 32'hDEAD_BEEF);   // must be ignored during the clear
    #2;
    checks++;
    if ({rf_we, stall_o, aux_ready, starve_o} !== 4'b0000 || aux_pend_mask !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b stall=%b rdy=%b starve=%b mask=%h, want all 0",
               rf_we, stall_o, aux_ready, starve_o, aux_pend_mask);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      #2;
      checks++;
      if ({rf_we, rf_ad, rf_wd, stall_o, aux_ready} !== {1'b1, 5'(i), 32'h0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_clear idx%0d: we=%b ad=%0d wd=%h stall=%b rdy=%b, want we=1 ad=%0d wd=0 stall=1 rdy=0",
                 i, rf_we, rf_ad, rf_wd, stall_o, aux_ready, i);
      end
      cyc();
    end
    drive_wb(1'b0, 5'd0, 32'h0);
    #2;
    checks++;
    if ({stall_o, rf_we, aux_ready, starve_o} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_run_entry: stall=%b we=%b rdy=%b starve=%b, want 0 0 1 0",
               stall_o, rf_we, aux_ready, starve_o);
    end
    cyc();
  endtask

  task automatic test_arbitration();
    drive_aux(1'b1, 5'd5, 32'hA5);
    drive_wb(1'b1, 5'd3, 32'h33);
    #2;
    checks++;
    if ({aux_ready, rf_we, rf_ad, rf_wd} !== {1'b1, 1'b1, 5'd3, 32'h33} || aux_pend_mask !== 32'h0) begin
      errors++;
      $display("FAIL arb_accept: rdy=%b we=%b ad=%0d wd=%h mask=%h, want rdy=1 x3=33 mask=0",
               aux_ready, rf_we, rf_ad, rf_wd, aux_pend_mask);
    end
    cyc();
    aux_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_wb(1'b1, 5'd3, 32'h34 + k);
      #2;
      checks++;
      if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd3, 32'(32'h34 + k)} || aux_pend_mask !== 32'h20) begin
        errors++;
        $display("FAIL arb_wb_prio c%0d: we=%b ad=%0d wd=%h mask=%h, want x3=%h mask=20",
                 k, rf_we, rf_ad, rf_wd, aux_pend_mask, 32'h34 + k);
      end
      cyc();
    end
    wb_we = 1'b0;
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd5, 32'hA5} || aux_pend_mask !== 32'h20) begin
      errors++;
      $display("FAIL arb_aux_write: we=%b ad=%0d wd=%h mask=%h, want x5=a5 mask=20",
               rf_we, rf_ad, rf_wd, aux_pend_mask);
    end
    cyc();
    #2;
    checks++;
    if (rf_we !== 1'b0 || aux_pend_mask !== 32'h0) begin
      errors++;
      $display("FAIL arb_drain: we=%b mask=%h, want we=0 mask=0", rf_we, aux_pend_mask);
    end
    cyc();
  endtask

  task automatic test_squash();
    // Older queued x7 superseded by a writeback.
    drive_aux(1'b1, 5'd7, 32'h11);
    drive_wb(1'b1, 5'd2, 32'h2);
    cyc();
    aux_valid = 1'b0;
    drive_wb(1'b1, 5'd7, 32'h22);
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd7, 32'h22} || aux_pend_mask !== 32'h80) begin
      errors++;
      $display("FAIL squash_wb: we=%b ad=%0d wd=%h mask=%h, want x7=22 mask=80",
               rf_we, rf_ad, rf_wd, aux_pend_mask);
    end
    cyc();
    wb_we = 1'b0;
    #2;
    checks++;
    if (rf_we !== 1'b0 || aux_pend_mask !== 32'h0) begin
      errors++;
      $display("FAIL squash_no_stale: we=%b ad=%0d wd=%h mask=%h, want we=0 mask=0",
               rf_we, rf_ad, rf_wd, aux_pend_mask);
    end
    cyc();
    // Same-cycle enqueue to the same rd is newer and survives.
    drive_wb(1'b1, 5'd7, 32'h33);
    drive_aux(1'b1, 5'd7, 32'h44);
    cyc();
    aux_valid = 1'b0;
    wb_we     = 1'b0;
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd7, 32'h44} || aux_pend_mask !== 32'h80) begin
      errors++;
      $display("FAIL squash_same_cycle: we=%b ad=%0d wd=%h mask=%h, want x7=44 mask=80",
               rf_we, rf_ad, rf_wd, aux_pend_mask);
    end
    cyc();
    // Squashed head retired while writeback holds the port.
    drive_wb(1'b1, 5'd1, 32'h1);
    drive_aux(1'b1, 5'd8, 32'h88);
    cyc();
    drive_aux(1'b1, 5'd9, 32'h99);
    cyc();
    aux_valid = 1'b0;
    drive_wb(1'b1, 5'd8, 32'h80);
    #2;
    checks++;
    if (aux_pend_mask !== 32'h300) begin
      errors++;
      $display("FAIL squash_mask_pre: mask=%h, want 300", aux_pend_mask);
    end
    cyc();
    drive_wb(1'b1, 5'd1, 32'h1);
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd1, 32'h1} || aux_pend_mask !== 32'h200) begin
      errors++;
      $display("FAIL squash_head_pop: we=%b ad=%0d wd=%h mask=%h, want x1=1 mask=200",
               rf_we, rf_ad, rf_wd, aux_pend_mask);
    end
    cyc();
    wb_we = 1'b0;
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd9, 32'h99}) begin
      errors++;
      $display("FAIL squash_next_head: we=%b ad=%0d wd=%h, want x9=99", rf_we, rf_ad, rf_wd);
    end
    cyc();
  endtask

  task automatic test_full();
    logic [4:0] rds [4];
    rds = '{5'd10, 5'd11, 5'd10, 5'd12};
    for (int k = 0; k < 4; k++) begin
      drive_wb(1'b1, 5'd1, 32'(k));
      drive_aux(1'b1, rds[k], 32'(k + 1));
      #2;
      checks++;
      if (aux_ready !== 1'b1 || rf_ad !== 5'd1) begin
        errors++;
        $display("FAIL full_fill k%0d: rdy=%b ad=%0d, want rdy=1 ad=1", k, aux_ready, rf_ad);
      end
      cyc();
    end
    drive_aux(1'b1, 5'd13, 32'h5);
    #2;
    checks++;
    if (aux_ready !== 1'b0 || aux_pend_mask !== 32'h1C00) begin
      errors++;
      $display("FAIL full_block: rdy=%b mask=%h, want rdy=0 mask=1c00", aux_ready, aux_pend_mask);
    end
    cyc();
    drive_wb(1'b1, 5'd0, 32'hFFFF);
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd, aux_ready} !== {1'b1, 5'd10, 32'h1, 1'b1}) begin
      errors++;
      $display("FAIL full_x0_free: we=%b ad=%0d wd=%h rdy=%b, want x10=1 rdy=1",
               rf_we, rf_ad, rf_wd, aux_ready);
    end
    cyc();
    aux_valid = 1'b0;
    wb_we     = 1'b0;
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd11, 32'h2} || aux_pend_mask !== 32'h3C00) begin
      errors++;
      $display("FAIL full_drain1: we=%b ad=%0d wd=%h mask=%h, want x11=2 mask=3c00",
               rf_we, rf_ad, rf_wd, aux_pend_mask);
    end
    cyc();
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd10, 32'h3}) begin
      errors++;
      $display("FAIL full_dup_order: we=%b ad=%0d wd=%h, want x10=3", rf_we, rf_ad, rf_wd);
    end
    cyc();
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd12, 32'h4}) begin
      errors++;
      $display("FAIL full_drain3: we=%b ad=%0d wd=%h, want x12=4", rf_we, rf_ad, rf_wd);
    end
    cyc();
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd13, 32'h5}) begin
      errors++;
      $display("FAIL full_late_push: we=%b ad=%0d wd=%h, want x13=5", rf_we, rf_ad, rf_wd);
    end
    cyc();
    #2;
    checks++;
    if (rf_we !== 1'b0 || aux_pend_mask !== 32'h0) begin
      errors++;
      $display("FAIL full_empty: we=%b mask=%h, want 0 0", rf_we, aux_pend_mask);
    end
    cyc();
  endtask

  task automatic test_x0();
    drive_aux(1'b1, 5'd0, 32'hBAD);
    drive_wb(1'b1, 5'd0, 32'h123);
    #2;
    checks++;
    if (aux_ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL x0_both: rdy=%b we=%b, want rdy=1 we=0", aux_ready, rf_we);
    end
    cyc();
    aux_valid = 1'b0;
    wb_we     = 1'b0;
    #2;
    checks++;
    if (rf_we !== 1'b0 || aux_pend_mask !== 32'h0) begin
      errors++;
      $display("FAIL x0_dropped: we=%b ad=%0d mask=%h, want we=0 mask=0", rf_we, rf_ad, aux_pend_mask);
    end
    cyc();
  endtask

  task automatic test_starve();
    drive_wb(1'b1, 5'd1, 32'h0);
    drive_aux(1'b1, 5'd20, 32'h2020);
    cyc();
    aux_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      #2;
      checks++;
      if (starve_o !== 1'b0 || rf_ad !== 5'd1) begin
        errors++;
        $display("FAIL starve_early age%0d: starve=%b ad=%0d, want starve=0 ad=1", j - 1, starve_o, rf_ad);
      end
      cyc();
    end
    #2;
    checks++;
    if (starve_o !== STARVE_EN || rf_ad !== 5'd1) begin
      errors++;
      $display("FAIL starve_assert: starve=%b ad=%0d, want starve=%b ad=1", starve_o, rf_ad, STARVE_EN);
    end
    cyc();
    wb_we = 1'b0;
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd, starve_o} !== {1'b1, 5'd20, 32'h2020, STARVE_EN}) begin
      errors++;
      $display("FAIL starve_bubble: we=%b ad=%0d wd=%h starve=%b, want x20=2020 starve=%b",
               rf_we, rf_ad, rf_wd, starve_o, STARVE_EN);
    end
    cyc();
    #2;
    checks++;
    if (starve_o !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL starve_release: starve=%b we=%b, want 0 0", starve_o, rf_we);
    end
    cyc();
  endtask

  task automatic test_clear();
    drive_wb(1'b1, 5'd1, 32'h1);
    drive_aux(1'b1, 5'd15, 32'hF);
    cyc();
    aux_valid = 1'b0;
    clear_req = 1'b1;
    #2;
    checks++;
    if (aux_pend_mask !== 32'h8000 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_pre: mask=%h stall=%b, want mask=8000 stall=0", aux_pend_mask, stall_o);
    end
    cyc();
    wb_we = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      clear_req = (i == 12);
      #2;
      checks++;
      if ({rf_we, rf_ad, rf_wd, stall_o} !== {1'b1, 5'(i), 32'h0, 1'b1} || aux_pend_mask !== 32'h0) begin
        errors++;
        $display("FAIL clear_walk idx%0d: we=%b ad=%0d wd=%h stall=%b mask=%h, want ad=%0d stall=1 mask=0",
                 i, rf_we, rf_ad, rf_wd, stall_o, aux_pend_mask, i);
      end
      cyc();
    end
    clear_req = 1'b0;
    rst_n     = 1'b0;
    #2;
    checks++;
    if ({rf_we, rf_ad, rf_wd, stall_o, aux_ready, starve_o} !== {1'b0, 5'd0, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL clear_rst_low: we=%b ad=%0d stall=%b rdy=%b starve=%b, want all 0",
               rf_we, rf_ad, stall_o, aux_ready, starve_o);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      #2;
      checks++;
      if ({rf_we, rf_ad, rf_wd, stall_o} !== {1'b1, 5'(i), 32'h0, 1'b1}) begin
        errors++;
        $display("FAIL clear_restart idx%0d: we=%b ad=%0d wd=%h stall=%b, want ad=%0d stall=1",
                 i, rf_we, rf_ad, rf_wd, stall_o, i);
      end
      cyc();
    end
    #2;
    checks++;
    if ({stall_o, rf_we, aux_ready} !== 3'b001 || aux_pend_mask !== 32'h0) begin
      errors++;
      $display("FAIL clear_done: stall=%b we=%b rdy=%b mask=%h, want 0 0 1 mask=0",
               stall_o, rf_we, aux_ready, aux_pend_mask);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_squash();
    test_full();
    test_x0();
    test_starve();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler for the 32x32 register file. It owns the file's single write port (`we3`/`ad3`/`wd3`) and shares it between two sources: the pipeline writeback stage, which has fixed priority, and an auxiliary requester such as a multi-cycle unit or debug port, whose writes go through a small ordered queue. It also runs a register-clear sequence after reset or on request, and exports a pending-write mask for hazard detection.

## Interface
Parameters:
- `AUX_DEPTH`, 4: aux queue entries (power of two, ≥2).
- `STARVE_LIM`, 8: cycles a queued aux write may wait before a starve request.

Ports:
- `clk`  in  1  core clock; the register file latches on the negedge of the same cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear_req`  in  1  pulse to start a clear sequence.
- `wb_we`  in  1  writeback write enable.
- `wb_rd`  in  5  writeback destination register.
- `wb_data`  in  32  writeback data.
- `aux_valid`  in  1  aux request valid.
- `aux_ready`  out  1  aux request accepted when high with `aux_valid`.
- `aux_rd`  in  5  aux destination register.
- `aux_data`  in  32  aux data.
- `rf_we`  out  1  to the register file `we3`.
- `rf_ad`  out  5  to the register file `ad3`.
- `rf_wd`  out  32  to the register file `wd3`.
- `stall_o`  out  1  pipeline must hold; high while clearing.
- `starve_o`  out  1  request that the pipeline insert a writeback bubble.
- `aux_pend_mask`  out  32  bit r is high when a valid queued write targets xr. Bit 0 is always 0.

## Operation
FSM states:
- **ST_CLEAR:**
  - Counter `idx` walks 1→31; the block drives `rf_we=1`, `rf_ad=idx`, `rf_wd=0`.
  - `stall_o=1` and `aux_ready=0`. Writeback inputs are ignored.
  - After the idx=31 cycle the FSM moves to ST_RUN.
- **ST_RUN:**
  - **Port selection:** if `wb_we && wb_rd!=0`, the port carries the writeback write, combinationally and with zero latency. Otherwise, if the queue head is valid, the head is written and popped. Otherwise `rf_we=0`.
  - **Writeback to x0:** treated as no write; the port is free for the queue.
  - **Aux acceptance:** `aux_ready = !full`. An accepted request with `aux_rd==0` is dropped and not enqueued.
  - **Squash:** a writeback write to rd invalidates every queued entry whose rd matches. The older aux value is superseded.
    - An aux request enqueued in the same cycle to the same rd counts as newer and is not squashed.
  - **Squashed heads:** an invalid head is popped without a write. This pop may happen in the same cycle as a writeback write.
  - **Duplicate rd:** entries with the same rd are kept and written in order.
  - **`clear_req` in ST_RUN:** the queue is flushed, the mask is cleared, and the FSM enters ST_CLEAR with idx=1 on the next cycle.
  - **`clear_req` in ST_CLEAR:** ignored.
- **Reset (`rst_n` low, any time, including mid-clear):**
  - State is ST_CLEAR with idx=1, the queue is empty and the age counter is 0.
  - All outputs are forced to 0 while `rst_n` is low.

## Timing
- Writeback path: combinational pass-through; the write lands in the same cycle.
- Aux request accepted at posedge N:
  - earliest `rf_we` for it is in cycle N+1;
  - its mask bit is set from cycle N+1 until the posedge that ends its write (or squash) cycle.
- Clear sequence: 31 cycles, from the first cycle after `rst_n` rises or after `clear_req` is sampled. `stall_o` is high for exactly those cycles.
- Full queue: `aux_ready=0`. A pop and a push in the same cycle are allowed when full only if the pop happens; `aux_ready` reflects that cycle's pop.
- Age counter:
  - counts cycles in which the head is valid and not written;
  - clears on pop;
  - saturates at `STARVE_LIM`.
- `starve_o`: high while age ≥ `STARVE_LIM`. The pipeline bubbles on the following cycle.

## Configuration
- `RF_SCHED_STARVE_EN` defined: the age counter is built and `starve_o` behaves as described under Timing.
- `RF_SCHED_STARVE_EN` undefined: no counter is built and `starve_o` is tied to 0. Aux writes can then wait indefinitely under continuous writeback traffic.

## Structure
- Package `rf_sched_pkg`:
  - state enum `ST_CLEAR`, `ST_RUN`;
  - `NREG=32`, `REG_AW=5`, `XLEN=32`;
  - queue entry struct: valid, rd, data.
- Sub-module `rf_aux_fifo`: circular storage with per-entry valid bits, rd-match squash, and `aux_pend_mask` generation.
- The top level contains the FSM, port mux and age counter.

## Test plan
- **Reset release:** `rst_n` rises → 31 cycles with `rf_we=1`, `rf_ad`=1..31, `rf_wd=0`, `stall_o=1`; then `stall_o=0`.
- **Arbitration:** aux writes x5=0xA5 and continuous writeback writes to x3 for 3 cycles → x3 goes to the port each cycle, `aux_pend_mask[5]=1`; x5 is written in the first writeback-idle cycle, then bit 5 clears.
- **Squash:** queue holds x7=0x11; writeback writes x7=0x22 → the queued entry is squashed, x7 is never written with 0x11, and mask bit 7 clears after that cycle.
- **Full queue:** push 4 aux entries during continuous writeback → `aux_ready=0` on the fifth; a writeback to x0 frees the port, the head is written and `aux_ready` returns to 1.
- **Starvation (macro on):** writeback busy for 8 cycles with the queue non-empty → `starve_o=1` at age 8; one bubble writes the head and `starve_o` returns to 0.
- **Reset mid-operation:** `clear_req` pulse at idx=12 of a clear → ignored; `rst_n` pulsed low mid-clear → the clear restarts at idx=1 and the queue is empty.
